regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Issue-stage scoreboard and interlock controller for the five-stage core's register file. Tracks outstanding writes to each architectural register between decode/issue and writeback, and stalls issue while a source operand is still pending (read-after-write hazard). Sits beside the decode stage: it consumes decoded rs1/rs2/rd fields and the writeback-stage register-write signals, and it drives the issue handshake and pipeline stall.

## Interface
- NUM_REGS, 32, number of architectural registers; x0 is never tracked
- ADDR_W, 5, register index width; must equal clog2(NUM_REGS)
- CNT_W, 2, pending-write counter width per register; max outstanding writes per register = 2^CNT_W-1
- STAT_W, 16, stall-cycle statistic counter width
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- issue_valid  input  1  decode presents an instruction for issue
- issue_ready  output  1  scoreboard accepts the instruction this cycle
- issue_rs1, issue_rs2  input  ADDR_W  source register indices
- issue_rs1_used, issue_rs2_used  input  1  instruction actually reads that source
- issue_rd  input  ADDR_W  destination index
- issue_rd_we  input  1  instruction writes rd
- wb_valid  input  1  writeback stage writes the register file this cycle
- wb_rd  input  ADDR_W  writeback destination
- flush  input  1  squash all in-flight instructions (branch/jump redirect)
- stall  output  1  issue_valid && !issue_ready
- busy_vec  output  NUM_REGS  bit i = counter i nonzero (registered state view)
- stall_cycles  output  STAT_W  saturating count of cycles with stall high
- underflow_err  output  1  sticky: writeback to a register with zero pending writes

## Operation
- State: one CNT_W counter per register 1..NUM_REGS-1; register 0 is hardwired 0.
- Source hazard (per source s): s_used && s!=0 && cnt[s]!=0, except when wb_valid && wb_rd==s && cnt[s]==1; the register file is write-first, so same-cycle writeback resolves the hazard.
- Destination full: issue_rd_we && issue_rd!=0 && cnt[rd]==max && !(wb_valid && wb_rd==rd).
- issue_ready = !flush && no source hazard && !destination full. Combinational from current state and inputs; it does not depend on issue_valid.
- Accept = issue_valid && issue_ready. On accept with issue_rd_we && rd!=0: cnt[rd] increments.
- Writeback with wb_valid && wb_rd!=0 && cnt[wb_rd]!=0: cnt[wb_rd] decrements.
- Accept and writeback to the same register in one cycle: net change 0.
- Writeback with cnt[wb_rd]==0: counter unchanged; underflow_err sets and holds until reset.
- wb_rd==0 or issue_rd==0: no counter effect and no error.
- flush: all counters clear on the next edge. A same-cycle issue is not accepted (issue_ready=0) and a same-cycle writeback is discarded. underflow_err is unaffected.
- Writebacks that arrive after a flush for instructions that were squashed before writeback are not possible by pipeline contract; if one does arrive, it falls under the underflow rule.
- stall_cycles increments every cycle stall=1 and saturates at all-ones.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert by system): all counters 0, busy_vec=0, stall_cycles=0, underflow_err=0. With no inputs active, issue_ready=1 and stall=0.
- Reset asserted mid-operation clears state within the same cycle, regardless of pending issues or writebacks.
- issue_ready/stall: zero-cycle (combinational) response to inputs and state.
- Counter, busy_vec, stall_cycles and underflow_err updates are visible one cycle after the causing edge.
- Dependent back-to-back issue: the producer issues at cycle N and busy_vec[rd]=1 from N+1; the consumer stalls until the cycle its producer's wb_valid is high, and issues in that cycle.

## Test plan
- Reset, then idle: busy_vec=0, issue_ready=1, stall_cycles=0; assert reset mid-run with cnt[5]=2, and check busy_vec=0 immediately.
- RAW stall: issue rd=5 at cycle 0, then consumer rs1=5 at cycle 1 with wb rd=5 at cycle 3. Expect stall high for cycles 1-2, issue at cycle 3 via write-first bypass, stall_cycles=2, busy_vec[5]=0 at cycle 4.
- Saturation: issue rd=7 three times with no writeback. Expect busy_vec[7]=1 and a fourth issue with rd=7 stalled; the same fourth issue with concurrent wb rd=7 is accepted and cnt stays 3.
- x0 handling: issue rd=0 repeatedly, then rs1=0 used. Expect busy_vec=0, never stall, underflow_err=0 for wb rd=0.
- Flush: with cnt[3]=1 and cnt[9]=2, assert flush together with issue_valid and wb rd=3. Expect issue_ready=0 that cycle and busy_vec=0 next cycle.
- Underflow: wb rd=12 with cnt[12]=0. Expect underflow_err=1 next cycle, held through a later flush, cleared only by reset.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Issue-stage scoreboard and interlock for the register file.
//               Keeps a pending-write counter per architectural register
//               (x0 excluded) and holds issue while a source operand still
//               has an outstanding write (read-after-write hazard).
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               issue_*               - decoded instruction offered for issue
//               issue_ready, stall    - issue handshake / pipeline stall
//               wb_valid, wb_rd       - writeback-stage register write
//               flush                 - squash all in-flight instructions
//               busy_vec              - per-register pending-write view
//               stall_cycles          - saturating stall-cycle statistic
//               underflow_err         - sticky writeback-without-pending flag
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter int STAT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_rs1_used,
  input  logic                issue_rs2_used,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_rd_we,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [STAT_W-1:0]   stall_cycles,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  // Read view of all counters; entry 0 is the hardwired-zero x0.
  logic [CNT_W-1:0] w_cnt [NUM_REGS];

  logic [CNT_W-1:0] w_rs1_cnt, w_rs2_cnt, w_rd_cnt, w_wb_cnt;
  logic             w_rs1_haz, w_rs2_haz, w_rd_full;
  logic             w_inc, w_dec, w_underflow;

  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic              underflow_q, underflow_d;

  assign w_cnt[0]    = '0;
  assign busy_vec[0] = 1'b0;

  always_comb begin
    w_rs1_cnt = w_cnt[issue_rs1];
    w_rs2_cnt = w_cnt[issue_rs2];
    w_rd_cnt  = w_cnt[issue_rd];
    w_wb_cnt  = w_cnt[wb_rd];

    // A writeback retiring the last pending write of a source resolves the
    // hazard in the same cycle because the register file is write-first.
    w_rs1_haz = issue_rs1_used && (issue_rs1 != '0) && (w_rs1_cnt != '0) &&
                !(wb_valid && (wb_rd == issue_rs1) && (w_rs1_cnt == c_cnt_one));
    w_rs2_haz = issue_rs2_used && (issue_rs2 != '0) && (w_rs2_cnt != '0) &&
                !(wb_valid && (wb_rd == issue_rs2) && (w_rs2_cnt == c_cnt_one));

    // A full destination counter can still accept if a writeback to the same
    // register frees a slot this cycle (net change zero).
    w_rd_full = issue_rd_we && (issue_rd != '0) && (w_rd_cnt == c_cnt_max) &&
                !(wb_valid && (wb_rd == issue_rd));

    issue_ready = !flush && !w_rs1_haz && !w_rs2_haz && !w_rd_full;
    stall       = issue_valid && !issue_ready;

    w_inc       = issue_valid && issue_ready && issue_rd_we && (issue_rd != '0);
    // Writebacks in a flush cycle are discarded outright.
    w_dec       = !flush && wb_valid && (wb_rd != '0) && (w_wb_cnt != '0);
    w_underflow = !flush && wb_valid && (wb_rd != '0) && (w_wb_cnt == '0);
  end

  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
      localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(i);
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
          cnt_d = '0;
        end else begin
          // Increment and decrement on the same register cancel out.
          if (w_inc && (issue_rd == c_idx)) cnt_d = cnt_d + c_cnt_one;
          if (w_dec && (wb_rd == c_idx))    cnt_d = cnt_d - c_cnt_one;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign w_cnt[i]    = cnt_q;
      assign busy_vec[i] = |cnt_q;
    end
  endgenerate

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    underflow_d = underflow_q | w_underflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      underflow_q    <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      underflow_q    <= underflow_d;
    end
  end

  assign stall_cycles  = stall_cycles_q;
  assign underflow_err = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed self-checking bench for regfile_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_rs1_used, issue_rs2_used, issue_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush, stall;
  logic [31:0] busy_vec;
  logic [15:0] stall_cycles;
  logic        underflow_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .STAT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall(stall), .busy_vec(busy_vec), .stall_cycles(stall_cycles),
    .underflow_err(underflow_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0;
    issue_rs2_used = 0; issue_rd = 0; issue_rd_we = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd = rd; issue_rd_we = 1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    idle();
    rst_n = 0;
    #2;
    check("rst_busy", busy_vec, 32'h0);
    check("rst_stat", stall_cycles, 0);
    check("rst_uflow", underflow_err, 0);
    check("rst_ready", issue_ready, 1);
    check("rst_stall", stall, 0);
    step(); step();
    rst_n = 1;
    step();

    // ---------------- RAW stall with write-first bypass ----------------
    issue(5'd5);                          // cycle 0: producer
    #1 check("raw_prod_ready", issue_ready, 1);
    step();
    idle();
    issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1;   // consumer
    #1 check("raw_busy5", busy_vec, 32'h0000_0020);
    check("raw_stall_c1", stall, 1);
    step();
    #1 check("raw_stall_c2", stall, 1);
    step();
    wb_valid = 1; wb_rd = 5;              // cycle 3: writeback bypass
    #1 check("raw_bypass_ready", issue_ready, 1);
    check("raw_bypass_stall", stall, 0);
    step();
    idle();
    #1 check("raw_busy_clear", busy_vec, 32'h0);
    check("raw_stat", stall_cycles, 2);

    // ---------------- saturation on rd=7 ----------------
    issue(5'd7);
    step(); step(); step();
    idle();
    #1 check("sat_busy7", busy_vec, 32'h0000_0080);
    issue(5'd7);
    #1 check("sat_full_stall", stall, 1);
    step();
    wb_valid = 1; wb_rd = 7;
    #1 check("sat_full_wb_ready", issue_ready, 1);
    step();
    idle();
    wb_valid = 1; wb_rd = 7;
    step(); step();
    idle();
    #1 check("sat_cnt_still_1", busy_vec, 32'h0000_0080);
    wb_valid = 1; wb_rd = 7;
    step();
    idle();
    #1 check("sat_drained", busy_vec, 32'h0);
    check("sat_stat", stall_cycles, 3);
    check("sat_no_uflow", underflow_err, 0);

    // ---------------- x0 handling ----------------
    issue(5'd0);
    issue_rs1 = 0; issue_rs1_used = 1; issue_rs2 = 0; issue_rs2_used = 1;
    for (int k = 0; k < 3; k++) begin
      #1 check("x0_ready", issue_ready, 1);
      step();
    end
    idle();
    wb_valid = 1; wb_rd = 0;
    #1 check("x0_busy", busy_vec, 32'h0);
    step();
    idle();
    #1 check("x0_uflow", underflow_err, 0);
    check("x0_stat", stall_cycles, 3);

    // ---------------- flush ----------------
    issue(5'd3); step();
    issue(5'd9); step(); step();
    idle();
    #1 check("fl_busy_pre", busy_vec, 32'h0000_0208);
    flush = 1; issue(5'd4); wb_valid = 1; wb_rd = 3;
    #1 check("fl_ready", issue_ready, 0);
    check("fl_stall", stall, 1);
    step();
    idle();
    #1 check("fl_busy_post", busy_vec, 32'h0);
    check("fl_stat", stall_cycles, 4);
    check("fl_uflow", underflow_err, 0);

    // ---------------- underflow ----------------
    wb_valid = 1; wb_rd = 12;
    step();
    idle();
    #1 check("uf_set", underflow_err, 1);
    check("uf_busy", busy_vec, 32'h0);
    flush = 1;
    step();
    idle();
    #1 check("uf_held_flush", underflow_err, 1);

    // ---------------- mid-run asynchronous reset ----------------
    issue(5'd5); step(); step();
    idle();
    #1 check("mr_busy_pre", busy_vec, 32'h0000_0020);
    #1 rst_n = 0;
    #1 check("mr_busy", busy_vec, 32'h0);
    check("mr_uflow", underflow_err, 0);
    check("mr_stat", stall_cycles, 0);
    check("mr_ready", issue_ready, 1);
    step();
    rst_n = 1;
    issue(5'd5);
    step();
    idle();
    #1 check("mr_post_issue", busy_vec, 32'h0000_0020);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
